// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_pkg
//  Description : Shared types and constants for the SRAM device-side model.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

    // Width of the shared SRAM data bus
    localparam int c_DATA_W = 16;

    // Supported range of the read pipeline depth
    localparam int c_RL_MIN = 1;
    localparam int c_RL_MAX = 4;

    // Device-side bus state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sram_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_if
//  Description : SRAM pin-level control bundle (address and active-low
//                strobes). DATA is a resolved tristate net and stays a
//                plain inout port on the devices that share it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_if #(
    parameter int AW = 18
);
    logic [AW-1:0] ADDR;
    logic          CSX;
    logic          OEX;
    logic          WEX;

    // Controller side drives address and strobes
    modport master (output ADDR, CSX, OEX, WEX);
    // Memory device side only observes them
    modport slave  (input  ADDR, CSX, OEX, WEX);
endinterface
`default_nettype wire

// File: rtl/InOut.sv
`default_nettype none
// ============================================================================
//  Module      : InOut
//  Description : Bidirectional pad buffer. Drives PIN with dataW when dir is
//                high, otherwise releases it; dataR always mirrors the pin.
//  Revision    : 1.0 - initial release
// ============================================================================
module InOut #(
    parameter int WIDTH = 16
) (
    inout  wire  [WIDTH-1:0] PIN,
    input  logic [WIDTH-1:0] dataW,
    output logic [WIDTH-1:0] dataR,
    input  logic             dir
);

    assign PIN   = dir ? dataW : {WIDTH{1'bz}};
    assign dataR = PIN;

endmodule
`default_nettype wire

// File: rtl/sram_array.sv
`default_nettype none
// ============================================================================
//  Module      : sram_array
//  Description : 2**AW x 16 synchronous RAM backing the SRAM model. One write
//                address and one read address per clock; when both hit the
//                same word on the same edge the read returns the new data, so
//                a commit and a read of that word never yield a stale value.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_array
    import sram_pkg::*;
#(
    parameter int AW = 18
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [AW-1:0]       i_waddr,
    input  logic [c_DATA_W-1:0] i_wdata,
    input  logic                i_re,
    input  logic [AW-1:0]       i_raddr,
    output logic [c_DATA_W-1:0] o_rdata
);

    logic [c_DATA_W-1:0] r_mem [0:(2**AW)-1];
    logic [c_DATA_W-1:0] r_rdata;

    // Storage write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port with write-through on address collision
    always_ff @(posedge clk) begin
        if (i_re) begin
            if (i_we && (i_waddr == i_raddr)) begin
                r_rdata <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_raddr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : sram_responder
//  Description : Clocked stand-in for an external 16-bit asynchronous SRAM.
//                Pins are registered on entry; writes are committed when the
//                WEX pulse ends; DATA is driven only while a read window is
//                open on the live pins and the read pipeline holds valid data.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_responder
    import sram_pkg::*;
#(
    parameter int AW           = 18,
    parameter int READ_LATENCY = 1      // legal range c_RL_MIN..c_RL_MAX
) (
    input  logic                clk,
    input  logic                rst_n,
    sram_if.slave               bus,
    inout  wire  [c_DATA_W-1:0] DATA,
    output logic                err_addr,
    output logic [15:0]         wr_count
);

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic                w_data_in;
    logic [c_DATA_W-1:0] w_data_pin;
    logic                r_csx;
    logic                r_oex;
    logic                r_wex;
    logic [AW-1:0]       r_addr;
    logic [c_DATA_W-1:0] r_data;

    // Register every pin each cycle; strobes reset to their inactive level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csx  <= 1'b1;
            r_oex  <= 1'b1;
            r_wex  <= 1'b1;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_csx  <= bus.CSX;
            r_oex  <= bus.OEX;
            r_wex  <= bus.WEX;
            r_addr <= bus.ADDR;
            r_data <= w_data_pin;
        end
    end

    assign w_data_in = 1'b0;

    logic w_wr_cond;
    logic w_rd_cond;

    // Write requires only CSX and WEX, so a write always beats a read
    assign w_wr_cond = ~r_csx & ~r_wex;
    assign w_rd_cond = ~r_csx & ~r_oex & r_wex;

    // ------------------------------------------------------------------
    // Control FSM, pending write and status
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [AW-1:0]       r_pend_addr;
    logic [c_DATA_W-1:0] r_pend_data;
    logic                r_err;
    logic [15:0]         r_wr_count;
    logic                w_commit;

    // The edge that leaves WRITE is the edge that writes the array
    assign w_commit = (r_state == ST_WRITE) & (r_wex | r_csx);

    // State sequencing, last-sample-wins capture and sticky address check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pend_addr <= '0;
            r_pend_data <= '0;
            r_err       <= 1'b0;
            r_wr_count  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_cond) begin
                        r_state     <= ST_WRITE;
                        r_pend_addr <= r_addr;
                        r_pend_data <= r_data;
                    end else if (w_rd_cond) begin
                        r_state <= ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (w_commit) begin
                        r_state    <= ST_IDLE;
                        r_wr_count <= r_wr_count + 16'd1;
                    end else begin
                        r_pend_addr <= r_addr;
                        r_pend_data <= r_data;
                        if (r_addr != r_pend_addr) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (r_csx) begin
                        r_state <= ST_IDLE;
                    end else if (!r_wex) begin
                        r_state     <= ST_WRITE;
                        r_pend_addr <= r_addr;
                        r_pend_data <= r_data;
                    end else if (r_oex) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign err_addr = r_err;
    assign wr_count = r_wr_count;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [c_DATA_W-1:0] w_ram_q;

    sram_array #(
        .AW (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_commit),
        .i_waddr (r_pend_addr),
        .i_wdata (r_pend_data),
        .i_re    (w_rd_cond),
        .i_raddr (r_addr),
        .o_rdata (w_ram_q)
    );

    // ------------------------------------------------------------------
    // Read pipeline: the RAM output register is stage one
    // ------------------------------------------------------------------
    logic [READ_LATENCY-1:0] r_vld;
    logic [c_DATA_W-1:0]     w_rd_data;

    // Valid bit travels alongside the data through every stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_rd_cond;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    if (READ_LATENCY > 1) begin : g_pipe
        logic [c_DATA_W-1:0] r_pipe [READ_LATENCY-1];

        // Extra data stages beyond the RAM output register
        always_ff @(posedge clk) begin
            r_pipe[0] <= w_ram_q;
            for (int i = 1; i < READ_LATENCY - 1; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end

        assign w_rd_data = r_pipe[READ_LATENCY-2];
    end else begin : g_nopipe
        assign w_rd_data = w_ram_q;
    end

    // ------------------------------------------------------------------
    // Output drive: gated by the live pins so turnaround is immediate
    // ------------------------------------------------------------------
    logic w_drive;

    assign w_drive = r_vld[READ_LATENCY-1] & ~bus.CSX & ~bus.OEX & bus.WEX;

    InOut #(
        .WIDTH (c_DATA_W)
    ) u_io (
        .PIN   (DATA),
        .dataW (w_rd_data),
        .dataR (w_data_pin),
        .dir   (w_drive)
    );

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_responder
//  Description : Randomised scoreboard bench for sram_responder. A word-level
//                memory model predicts read data; a pin monitor decides when
//                a read window has matured and compares the bus against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_responder;
    import sram_pkg::*;

    localparam int AW = 10;
    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    wire  [15:0] DATA;
    logic        tb_drv;
    logic [15:0] tb_dout;
    logic        err_addr;
    logic [15:0] wr_count;

    sram_if #(.AW(AW)) bus ();

    assign DATA = tb_drv ? tb_dout : 16'hzzzz;

    sram_responder #(
        .AW           (AW),
        .READ_LATENCY (RL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .DATA     (DATA),
        .err_addr (err_addr),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] ref_mem [int];
    int          ref_wrc = 0;
    bit          ref_err = 1'b0;
    logic [15:0] exp_q [$];
    int          wr_addrs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: count consecutive edges with a stable read window on the pins
    int            run = 0;
    logic [AW-1:0] run_addr = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            run = 0;
        end else if (!bus.CSX && !bus.OEX && bus.WEX) begin
            if (run > 0 && bus.ADDR == run_addr) begin
                run++;
            end else begin
                run      = 1;
                run_addr = bus.ADDR;
            end
        end else begin
            run = 0;
        end
    end

    // Monitor: compare matured reads and check the responder releases DATA
    always @(negedge clk) begin
        if (tb_drv) begin
            check("bus_release", {16'h0, DATA}, {16'h0, tb_dout});
        end
        if (run == 1 + RL) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL read_unexpected: got %h expected none", DATA);
            end else begin
                check("read_data", {16'h0, DATA}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic idle(input int n);
        bus.CSX = 1'b1;
        bus.OEX = 1'b1;
        bus.WEX = 1'b1;
        tb_drv  = 1'b1;
        tb_dout = 16'h0000;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input int a);
        bus.CSX  = 1'b0;
        bus.OEX  = 1'b0;
        bus.WEX  = 1'b1;
        bus.ADDR = AW'(a);
        tb_drv   = 1'b0;
        exp_q.push_back(ref_mem.exists(a) ? ref_mem[a] : 16'h0000);
        repeat (RL + 2) @(posedge clk);
        #1;
    endtask

    // One WEX pulse of n cycles: first cycle (a1,d1), remaining cycles (a2,d2)
    task automatic wr(input int a1, input logic [15:0] d1, input int a2,
                      input logic [15:0] d2, input int n, input logic oex,
                      output int ca);
        logic [15:0] cd;
        for (int i = 0; i < n; i++) begin
            bus.CSX  = 1'b0;
            bus.WEX  = 1'b0;
            bus.OEX  = oex;
            bus.ADDR = AW'((i == 0) ? a1 : a2);
            tb_drv   = 1'b1;
            tb_dout  = (i == 0) ? d1 : d2;
            @(posedge clk);
            #1;
        end
        ca = (n > 1) ? a2 : a1;
        cd = (n > 1) ? d2 : d1;
        if (n > 1 && a2 != a1) ref_err = 1'b1;
        ref_mem[ca] = cd;
        ref_wrc     = (ref_wrc + 1) % 65536;
        wr_addrs.push_back(ca);
    endtask

    task automatic chk_status(input string tag);
        idle(2);
        check({tag, "_err_addr"}, {31'h0, err_addr}, {31'h0, ref_err});
        check({tag, "_wr_count"}, {16'h0, wr_count}, 32'(ref_wrc));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int ca;
        int a;
        int a2;
        int n;
        int op;

        // Reset held with an open read window: bus must stay released
        bus.CSX  = 1'b0;
        bus.OEX  = 1'b0;
        bus.WEX  = 1'b1;
        bus.ADDR = '0;
        tb_drv   = 1'b1;
        tb_dout  = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_err_addr", {31'h0, err_addr}, 32'h0);
        check("reset_wr_count", {16'h0, wr_count}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Single write then read
        wr(12'h012, 16'hBEEF, 12'h012, 16'hBEEF, 2, 1'b1, ca);
        rd(12'h012);
        chk_status("single");

        // Last sample within a pulse wins
        wr(5, 16'h1111, 5, 16'h2222, 2, 1'b1, ca);
        rd(5);
        chk_status("last_wins");

        // Address change mid-pulse: flag sticks, data lands at new address
        wr(5, 16'h3333, 6, 16'h4444, 2, 1'b1, ca);
        chk_status("glitch");
        rd(6);
        rd(5);

        // Write with OEX also asserted, read back-to-back, then turnaround
        wr(9, 16'h9999, 9, 16'h9A9A, 2, 1'b0, ca);
        rd(9);
        idle(1);
        chk_status("priority");

        // Randomised traffic
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 2));
            if (op == 0 || wr_addrs.size() == 0) begin
                a  = int'($urandom_range(0, 31));
                n  = int'($urandom_range(1, 3));
                a2 = ($urandom_range(0, 7) == 0) ? (a ^ 1) : a;
                wr(a, 16'($urandom), a2, 16'($urandom), n,
                   1'($urandom_range(0, 1)), ca);
                if ($urandom_range(0, 1) == 1) rd(ca);
                else idle(1);
            end else if (op == 1) begin
                rd(wr_addrs[$urandom_range(0, wr_addrs.size() - 1)]);
            end else begin
                idle(int'($urandom_range(1, 2)));
            end
        end
        chk_status("random");

        // Reset in the middle of a write pulse discards it
        wr(7, 16'h7777, 7, 16'h7777, 1, 1'b1, ca);
        idle(2);
        bus.CSX  = 1'b0;
        bus.WEX  = 1'b0;
        bus.OEX  = 1'b1;
        bus.ADDR = AW'(7);
        tb_dout  = 16'hDEAD;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b0;
        ref_wrc = 0;
        ref_err = 1'b0;
        bus.WEX = 1'b1;
        bus.OEX = 1'b0;
        tb_dout = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_err_addr", {31'h0, err_addr}, 32'h0);
        check("rst_mid_wr_count", {16'h0, wr_count}, 32'h0);
        @(negedge clk);
        #1;
        tb_drv = 1'b0;
        exp_q.push_back(ref_mem[7]);
        rst_n = 1'b1;
        repeat (RL + 2) @(posedge clk);
        #1;
        chk_status("after_rst");
        wr(3, 16'h0303, 3, 16'h0303, 1, 1'b1, ca);
        rd(3);
        chk_status("post_rst_write");

        idle(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
